// File: rtl/dcache_ctrl.sv
// Data cache controller: serves hits in place, writes back a dirty victim, refills
// the missing line and replays the access between the MEM stage, cache SRAM and data memory.
module dcache_ctrl #(
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256,
    parameter int WORD_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_data_i,
    input  logic                cpu_MemRead_i,
    input  logic                cpu_MemWrite_i,
    output logic [WORD_W-1:0]   cpu_data_o,
    output logic                cpu_stall_o,
    output logic [IDX_W-1:0]    cache_addr_o,
    output logic [TAG_W+1:0]    cache_tag_o,
    output logic [LINE_W-1:0]   cache_data_o,
    output logic                cache_enable_o,
    output logic                cache_write_o,
    input  logic [TAG_W+1:0]    sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic [31:0]         mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WSEL_W = $clog2(LINE_W / WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    state_t              state, state_nxt;
    logic [LINE_W-1:0]   victim_line;
    logic [31:0]         victim_addr;
    logic [LINE_W-1:0]   fill_line;

    logic                req;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic [WSEL_W-1:0]   wsel;
    logic [LINE_W-1:0]   store_line;
    logic                unused_bits;

    logic                stall;
    logic                cache_en;
    logic                cache_wr;
    logic                mem_en;
    logic                mem_wr;

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign tag         = cpu_addr_i[31 -: TAG_W];
    assign idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign wsel        = cpu_addr_i[OFF_W-1 -: WSEL_W];
    assign unused_bits = ^cpu_addr_i[1:0];

    assign cpu_data_o   = sram_data_i[WORD_W*int'(wsel) +: WORD_W];
    assign cache_addr_o = idx;

    // Store hit: the SRAM line with only the addressed word replaced.
    always_comb begin
        store_line = sram_data_i;
        store_line[WORD_W*int'(wsel) +: WORD_W] = cpu_data_i;
    end

    // NOTE: state and line registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            victim_line <= '0;
            victim_addr <= '0;
            fill_line   <= '0;
        end else begin
            state <= state_nxt;
            if (state == MISS) begin
                victim_line <= sram_data_i;
                victim_addr <= {sram_tag_i[TAG_W-1:0], idx, {OFF_W{1'b0}}};
            end
            if (state == ALLOCATE && mem_ack_i) begin
                fill_line <= mem_data_i;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt    = state;
        stall        = 1'b1;
        cache_en     = 1'b0;
        cache_wr     = 1'b0;
        cache_tag_o  = {2'b00, tag};
        cache_data_o = store_line;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
        mem_data_o   = victim_line;

        case (state)
            IDLE: begin
                stall    = req & ~sram_hit_i;
                cache_en = req;
                if (req && sram_hit_i && cpu_MemWrite_i) begin
                    cache_wr    = 1'b1;
                    cache_tag_o = {2'b11, tag};
                end
                if (req && !sram_hit_i) begin
                    state_nxt = MISS;
                end
            end
            MISS: begin
                // Keep the SRAM reading so the LRU victim is presented this cycle.
                cache_en  = 1'b1;
                state_nxt = (sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr_o = victim_addr;
                if (mem_ack_i) begin
                    state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_en = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                cache_en     = 1'b1;
                cache_wr     = 1'b1;
                cache_data_o = fill_line;
                cache_tag_o  = {2'b10, tag};
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset must silence the strobes even while IDLE decodes a live request.
    assign cpu_stall_o    = stall & rst_i;
    assign cache_enable_o = cache_en;
    assign cache_write_o  = cache_wr & rst_i;
    assign mem_enable_o   = mem_en & rst_i;
    assign mem_write_o    = mem_wr & rst_i;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: SRAM and memory environment models, directed
// vector table, hand-written corner sequences and randomized accesses vs. a reference cache.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   cache_addr_o;
    logic [24:0]  cache_tag_o;
    logic [255:0] cache_data_o;
    logic         cache_enable_o;
    logic         cache_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .cache_addr_o   (cache_addr_o),
        .cache_tag_o    (cache_tag_o),
        .cache_data_o   (cache_data_o),
        .cache_enable_o (cache_enable_o),
        .cache_write_o  (cache_write_o),
        .sram_tag_i     (sram_tag_i),
        .sram_data_i    (sram_data_i),
        .sram_hit_i     (sram_hit_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h0001_0003 + 32'h1357_9BDF;
    endfunction

    // ---------------- cache SRAM environment: 2 ways x 16 sets, LRU victim ----------------
    logic [22:0]  s_tag   [2][16];
    logic         s_valid [2][16];
    logic         s_dirty [2][16];
    logic [255:0] s_line  [2][16];
    logic         s_lru   [16];
    logic         sram_clr = 1'b1;
    logic         h0, h1, sel_way;

    always_comb begin
        h0          = s_valid[0][cache_addr_o] && (s_tag[0][cache_addr_o] == cpu_addr_i[31:9]);
        h1          = s_valid[1][cache_addr_o] && (s_tag[1][cache_addr_o] == cpu_addr_i[31:9]);
        sram_hit_i  = h0 | h1;
        sel_way     = h0 ? 1'b0 : (h1 ? 1'b1 : s_lru[cache_addr_o]);
        sram_tag_i  = {s_valid[sel_way][cache_addr_o], s_dirty[sel_way][cache_addr_o],
                       s_tag[sel_way][cache_addr_o]};
        sram_data_i = s_line[sel_way][cache_addr_o];
    end

    always @(posedge clk) begin
        if (sram_clr) begin
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < 16; s++) begin
                    s_valid[w][s] <= 1'b0;
                    s_dirty[w][s] <= 1'b0;
                    s_tag[w][s]   <= '0;
                    s_line[w][s]  <= '0;
                end
            end
            for (int s = 0; s < 16; s++) s_lru[s] <= 1'b0;
        end else if (cache_enable_o) begin
            if (cache_write_o) begin
                s_valid[sel_way][cache_addr_o] <= cache_tag_o[24];
                s_dirty[sel_way][cache_addr_o] <= cache_tag_o[23];
                s_tag[sel_way][cache_addr_o]   <= cache_tag_o[22:0];
                s_line[sel_way][cache_addr_o]  <= cache_data_o;
                s_lru[cache_addr_o]            <= ~sel_way;
            end else if (sram_hit_i) begin
                s_lru[cache_addr_o] <= ~sel_way;
            end
        end
    end

    // ---------------- data memory environment: ack on the Nth cycle of a request ----------------
    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t         txn_q[$];
    logic [255:0] mem_model [logic [31:0]];
    int           wb_delay   = 1;
    int           fill_delay = 1;
    logic         glitch_ack = 1'b0;
    logic         env_ack    = 1'b0;
    int           env_cnt    = 0;

    assign mem_ack_i = env_ack | glitch_ack;

    function automatic logic [255:0] mem_get(input logic [31:0] la);
        logic [255:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
        return l;
    endfunction

    always @(negedge clk or negedge rst_i) begin
        if (!rst_i) begin
            env_ack = 1'b0;
            env_cnt = 0;
        end else begin
            if (env_ack) begin
                env_ack = 1'b0;
                env_cnt = 0;
            end
            if (mem_enable_o) begin
                env_cnt++;
                if (env_cnt >= (mem_write_o ? wb_delay : fill_delay)) begin
                    env_ack = 1'b1;
                    if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
                    else mem_data_i = mem_get(mem_addr_o);
                    txn_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
                end
            end else begin
                env_cnt = 0;
            end
        end
    end

    // ---------------- reference: architectural memory + per-set LRU list of resident lines ----------------
    logic [31:0] golden [logic [31:0]];
    logic [22:0] ref_tag   [16][2];
    bit          ref_dirty [16][2];
    int          ref_cnt   [16];

    function automatic logic [31:0] golden_word(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_word(a);
    endfunction

    function automatic logic [255:0] golden_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = golden_word(la + 32'(w * 4));
        return l;
    endfunction

    task automatic ref_step(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output bit hit, output bit wb, output logic [31:0] wb_addr);
        int          s;
        int          pos;
        logic [22:0] t;
        bit          d;
        s       = int'(addr[8:5]);
        t       = addr[31:9];
        pos     = -1;
        wb      = 1'b0;
        wb_addr = '0;
        for (int i = 0; i < ref_cnt[s]; i++) if (ref_tag[s][i] == t) pos = i;
        hit = (pos >= 0);
        if (hit) begin
            d = ref_dirty[s][pos] | wr;
            if (pos == 1) begin
                ref_tag[s][1]   = ref_tag[s][0];
                ref_dirty[s][1] = ref_dirty[s][0];
            end
        end else begin
            d = wr;
            if (ref_cnt[s] == 2) begin
                wb      = ref_dirty[s][1];
                wb_addr = {ref_tag[s][1], addr[8:5], 5'b0};
            end else begin
                ref_cnt[s]++;
            end
            ref_tag[s][1]   = ref_tag[s][0];
            ref_dirty[s][1] = ref_dirty[s][0];
        end
        ref_tag[s][0]   = t;
        ref_dirty[s][0] = d;
        if (wr) golden[{addr[31:2], 2'b00}] = wdata;
    endtask

    // ---------------- access driver ----------------
    task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input int wbd, input int fd,
                              output int stalls, output logic [31:0] rdata, output int base);
        wb_delay   = wbd;
        fill_delay = fd;
        base       = txn_q.size();
        @(negedge clk);
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        cpu_MemWrite_i = wr;
        cpu_MemRead_i  = rd;
        #1;
        stalls = 0;
        while (cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = cpu_data_o;
        @(posedge clk);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic check_access(input bit wr, input bit rd, input logic [31:0] addr,
                                input logic [31:0] wdata, input int wbd, input int fd,
                                input string name);
        bit          hit, wb;
        logic [31:0] wb_addr, rdata;
        int          stalls, base, ntx, k, exp_ntx;
        ref_step(wr, addr, wdata, hit, wb, wb_addr);
        run_access(wr, rd, addr, wdata, wbd, fd, stalls, rdata, base);
        ntx     = txn_q.size() - base;
        exp_ntx = hit ? 0 : (wb ? 2 : 1);
        check({name, "_stall"}, 256'(stalls), hit ? 256'(0) : 256'(3 + (wb ? wbd : 0) + fd));
        if (!wr) check({name, "_rdata"}, rdata, golden_word({addr[31:2], 2'b00}));
        check({name, "_ntx"}, 256'(ntx), 256'(exp_ntx));
        if (!hit && ntx == exp_ntx) begin
            k = base;
            if (wb) begin
                check({name, "_wb_addr"}, {txn_q[k].wr, txn_q[k].addr}, {1'b1, wb_addr});
                check({name, "_wb_line"}, txn_q[k].data, golden_line(wb_addr));
                k++;
            end
            check({name, "_fill_addr"}, {txn_q[k].wr, txn_q[k].addr}, {1'b0, addr[31:5], 5'b0});
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wbd;
        int          fd;
        int          exp_stall;
        logic [31:0] exp_rdata;
        int          exp_ntx;
    } vec_t;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[5];
        bit          hit, wb;
        logic [31:0] wb_addr, rdata, a;
        int          stalls, base, ntx, n;
        bit          wr, rd;

        vecs[0] = '{1'b0, 32'h0000_0044, 32'h0,         1, 4, 7, init_word(32'h44),  1};
        vecs[1] = '{1'b1, 32'h0000_0048, 32'hDEADBEEF,  1, 1, 0, 32'h0,              0};
        vecs[2] = '{1'b0, 32'h0000_0048, 32'h0,         1, 1, 0, 32'hDEADBEEF,       0};
        vecs[3] = '{1'b0, 32'h0000_0240, 32'h0,         1, 1, 4, init_word(32'h240), 1};
        vecs[4] = '{1'b0, 32'h0000_0440, 32'h0,         2, 3, 8, init_word(32'h440), 2};
        for (int s = 0; s < 16; s++) ref_cnt[s] = 0;

        // Reset with a live missing request: strobes must stay quiet.
        rst_i          = 1'b0;
        cpu_addr_i     = 32'h0000_0044;
        cpu_data_i     = 32'h0;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", cpu_stall_o, 0);
        check("reset_mem_en", mem_enable_o, 0);
        check("reset_mem_wr", mem_write_o, 0);
        check("reset_cache_wr", cache_write_o, 0);
        sram_clr      = 1'b0;
        cpu_MemRead_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;

        // Reset in the middle of ALLOCATE, then a stale ack.
        wb_delay   = 1000;
        fill_delay = 1000;
        @(negedge clk);
        cpu_addr_i    = 32'h0000_1000;
        cpu_MemRead_i = 1'b1;
        #1;
        n = 0;
        while (!mem_enable_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t1_alloc_req", {mem_enable_o, mem_write_o}, 2'b10);
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("t1_rst_mem_en", mem_enable_o, 0);
        check("t1_rst_stall", cpu_stall_o, 0);
        cpu_MemRead_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        glitch_ack = 1'b1;
        @(negedge clk);
        glitch_ack = 1'b0;
        #1;
        check("t1_late_ack_mem_en", mem_enable_o, 0);
        check("t1_late_ack_stall", cpu_stall_o, 0);
        check("t1_late_ack_cache_en", cache_enable_o, 0);

        // Directed vector table: cold miss, store hit, load hit, clean and dirty conflict misses.
        for (int i = 0; i < 5; i++) begin
            ref_step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, hit, wb, wb_addr);
            run_access(vecs[i].wr, ~vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wbd,
                       vecs[i].fd, stalls, rdata, base);
            ntx = txn_q.size() - base;
            check($sformatf("vec%0d_stall", i), 256'(stalls), 256'(vecs[i].exp_stall));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_ntx", i), 256'(ntx), 256'(vecs[i].exp_ntx));
            if (i == 0 && ntx == 1) begin
                check("vec0_fill_addr", {txn_q[base].wr, txn_q[base].addr}, {1'b0, 32'h0000_0040});
                check("vec0_refill_tag", {s_valid[0][2], s_dirty[0][2], s_tag[0][2]}, 25'h100_0000);
            end
            if (i == 1) begin
                check("vec1_sram_word2", s_line[0][2][95:64], 32'hDEADBEEF);
                check("vec1_sram_dirty", s_dirty[0][2], 1'b1);
            end
            if (i == 4 && ntx == 2) begin
                check("vec4_wb", {txn_q[base].wr, txn_q[base].addr}, {1'b1, 32'h0000_0040});
                check("vec4_wb_word2", txn_q[base].data[95:64], 32'hDEADBEEF);
                check("vec4_fill", {txn_q[base+1].wr, txn_q[base+1].addr}, {1'b0, 32'h0000_0440});
            end
        end

        // Load hit on a clean line while mem_ack_i is stuck high.
        ref_step(1'b0, 32'h0000_0244, 32'h0, hit, wb, wb_addr);
        @(negedge clk);
        cpu_addr_i    = 32'h0000_0244;
        cpu_MemRead_i = 1'b1;
        glitch_ack    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t5_stall_%0d", k), cpu_stall_o, 0);
            check($sformatf("t5_mem_en_%0d", k), mem_enable_o, 0);
            check($sformatf("t5_rdata_%0d", k), cpu_data_o, golden_word(32'h0000_0244));
            @(negedge clk);
        end
        glitch_ack    = 1'b0;
        cpu_MemRead_i = 1'b0;

        // Request withdrawn during MISS: refill still completes, replay then hits.
        ref_step(1'b0, 32'h0000_1020, 32'h0, hit, wb, wb_addr);
        wb_delay   = 1;
        fill_delay = 3;
        @(negedge clk);
        cpu_addr_i    = 32'h0000_1020;
        cpu_MemRead_i = 1'b1;
        @(negedge clk);
        #1;
        cpu_MemRead_i = 1'b0;
        n = 0;
        while (cpu_stall_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drop_stall_cycles", 256'(n), 256'(5));
        check_access(1'b0, 1'b1, 32'h0000_1020, 32'h0, 1, 1, "drop_replay");

        // Randomized traffic over a few conflicting sets.
        for (int i = 0; i < 250; i++) begin
            a  = {21'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 2'b00};
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            check_access(wr, rd, a, $urandom, $urandom_range(1, 3), $urandom_range(1, 3),
                         $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
